// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared directions, states and reversal rule for the snake move scheduler
package snake_pkg;

   localparam int GRID_W_DEF = 32;
   localparam int GRID_H_DEF = 24;

   localparam logic [2:0] DIR_LEFT  = 3'b000;
   localparam logic [2:0] DIR_RIGHT = 3'b001;
   localparam logic [2:0] DIR_UP    = 3'b100;
   localparam logic [2:0] DIR_DOWN  = 3'b110;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT_ACK,
      HALT
   } state_t;

   // Same axis, opposite sign: bit1 carries the sign on the vertical axis, bit0 on the horizontal
   function automatic logic is_reversal(input logic [2:0] cand, input logic [2:0] cur);
      logic cand_sign;
      logic cur_sign;
      cand_sign = cand[2] ? cand[1] : cand[0];
      cur_sign  = cur[2]  ? cur[1]  : cur[0];
      return (cand[2] == cur[2]) && (cand_sign != cur_sign);
   endfunction

endpackage

// File: rtl/snake_move_sched_if.sv
// rtl/snake_move_sched_if.sv - step offer bus between the move scheduler and the body/draw unit
interface snake_move_sched_if
   import snake_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF
) ();

   logic                      step_valid;
   logic                      step_ack;
   logic [$clog2(GRID_W)-1:0] head_x;
   logic [$clog2(GRID_H)-1:0] head_y;
   logic [2:0]                cur_dir;
   logic                      wall_hit;

   modport master (
      output step_valid, head_x, head_y, cur_dir, wall_hit,
      input  step_ack
   );

   modport slave (
      input  step_valid, head_x, head_y, cur_dir, wall_hit,
      output step_ack
   );

endinterface

// File: rtl/snake_move_sched_next_head.sv
// rtl/snake_move_sched_next_head.sv - next head cell for one step, with wrap or wall detection
module snake_next_head
   import snake_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF,
   parameter int WRAP   = 1
) (
   input  logic [$clog2(GRID_W)-1:0] head_x,
   input  logic [$clog2(GRID_H)-1:0] head_y,
   input  logic [2:0]                dir,
   output logic [$clog2(GRID_W)-1:0] nx,
   output logic [$clog2(GRID_H)-1:0] ny,
   output logic                      out_of_bounds
);

   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);

   logic [XW:0] x_ext;
   logic [YW:0] y_ext;
   logic        edge_cross;

   // One extra bit catches underflow (MSB set) and overflow (equals grid size)
   always_comb begin
      x_ext      = {1'b0, head_x};
      y_ext      = {1'b0, head_y};
      nx         = head_x;
      ny         = head_y;
      edge_cross = 1'b0;
      if (dir[2]) begin
         y_ext = dir[1] ? y_ext + (YW+1)'(1) : y_ext - (YW+1)'(1);
         if (y_ext[YW]) begin
            edge_cross = 1'b1;
            ny         = YW'(GRID_H - 1);
         end else if (y_ext == (YW+1)'(GRID_H)) begin
            edge_cross = 1'b1;
            ny         = '0;
         end else begin
            ny = y_ext[YW-1:0];
         end
      end else begin
         x_ext = dir[0] ? x_ext + (XW+1)'(1) : x_ext - (XW+1)'(1);
         if (x_ext == (XW+1)'(GRID_W)) begin
            edge_cross = 1'b1;
            nx         = '0;
         end else if (x_ext[XW]) begin
            edge_cross = 1'b1;
            nx         = XW'(GRID_W - 1);
         end else begin
            nx = x_ext[XW-1:0];
         end
      end
      out_of_bounds = edge_cross && (WRAP == 0);
   end

endmodule

// File: rtl/snake_move_sched.sv
// rtl/snake_move_sched.sv - snake head move scheduler: reversal filter, step timer, step handshake
module snake_move_sched
   import snake_pkg::*;
#(
   parameter int TICK_DIV = 4,
   parameter int GRID_W   = GRID_W_DEF,
   parameter int GRID_H   = GRID_H_DEF,
   parameter int WRAP     = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [2:0]          dir_in,
   input  logic                dir_lock,
   snake_move_sched_if.master  step
);

   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam int CW = $clog2(TICK_DIV);

   state_t        state_q, state_d;
   logic [XW-1:0] hx_q, hx_d;
   logic [YW-1:0] hy_q, hy_d;
   logic [2:0]    cur_q, cur_d;
   logic [2:0]    pend_q, pend_d;
   logic [CW-1:0] tick_q, tick_d;
   logic          valid_q, valid_d;
   logic          wall_q, wall_d;

   logic [XW-1:0] nx;
   logic [YW-1:0] ny;
   logic          oob;

   snake_next_head #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .WRAP   (WRAP)
   ) u_next_head (
      .head_x        (hx_q),
      .head_y        (hy_q),
      .dir           (pend_q),
      .nx            (nx),
      .ny            (ny),
      .out_of_bounds (oob)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         hx_q    <= XW'(GRID_W / 2);
         hy_q    <= YW'(GRID_H / 2);
         cur_q   <= DIR_LEFT;
         pend_q  <= DIR_LEFT;
         tick_q  <= '0;
         valid_q <= 1'b0;
         wall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hx_q    <= hx_d;
         hy_q    <= hy_d;
         cur_q   <= cur_d;
         pend_q  <= pend_d;
         tick_q  <= tick_d;
         valid_q <= valid_d;
         wall_q  <= wall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hx_d    = hx_q;
      hy_d    = hy_q;
      cur_d   = cur_q;
      pend_d  = pend_q;
      tick_d  = tick_q;
      valid_d = valid_q;
      wall_d  = wall_q;

      // Last legal press before the tick wins; reversals judged against the committed direction
      if (state_q != HALT && dir_lock && !is_reversal(dir_in, cur_q))
         pend_d = dir_in;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = RUN;
               tick_d  = '0;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               tick_d  = '0;
            end else if (tick_q == CW'(TICK_DIV - 1)) begin
               tick_d = '0;
               if (oob) begin
                  wall_d  = 1'b1;
                  state_d = HALT;
               end else begin
                  hx_d    = nx;
                  hy_d    = ny;
                  cur_d   = pend_q;
                  valid_d = 1'b1;
                  state_d = WAIT_ACK;
               end
            end else begin
               tick_d = tick_q + CW'(1);
            end
         end
         WAIT_ACK: begin
            if (step.step_ack && valid_q) begin
               valid_d = 1'b0;
               state_d = RUN;
            end
         end
         HALT: ;
         default: state_d = IDLE;
      endcase
   end

   assign step.step_valid = valid_q;
   assign step.head_x     = hx_q;
   assign step.head_y     = hy_q;
   assign step.cur_dir    = cur_q;
   assign step.wall_hit   = wall_q;

endmodule
